// File: rtl/lm32_wb_burst_ram_pkg.sv
// Shared Wishbone cycle/burst type codes and FSM encoding for the LM32 burst RAM slave.
package lm32_wb_burst_ram_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ACK   = 3'd2,
    S_BURST = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  function automatic logic cti_supported(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_END);
  endfunction

endpackage

// File: rtl/lm32_wb_ram_core.sv
// Synchronous RAM, one read and one write port, byte write enables, write-first read.
module lm32_wb_ram_core #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]            wr_sel,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Only the output register is reset; array contents persist across reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        rd_data[8*i +: 8] <= (wr_en && wr_sel[i] && (wr_addr == rd_addr)) ?
                             wr_data[8*i +: 8] : mem[rd_addr][8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/lm32_wb_burst_ram.sv
// Wishbone B3 slave RAM for the LM32 masters: classic cycles plus registered-feedback
// incrementing bursts (linear / wrap4 / wrap8 / wrap16).
module lm32_wb_burst_ram
  import lm32_wb_burst_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] S_ADR_I,
  input  logic [31:0] S_DAT_I,
  input  logic [3:0]  S_SEL_I,
  input  logic        S_WE_I,
  input  logic [2:0]  S_CTI_I,
  input  logic [1:0]  S_BTE_I,
  input  logic        S_LOCK_I,
  input  logic        S_CYC_I,
  input  logic        S_STB_I,
  output logic [31:0] S_DAT_O,
  output logic        S_ACK_O,
  output logic        S_ERR_O,
  output logic        S_RTY_O
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   req_addr, rd_addr;
  logic [1:0]              cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    burst_q, burst_d;
  logic                    hit, rd_en, wr_en;
  logic                    unused;

  assign unused = ^{S_LOCK_I, S_ADR_I[1:0]};

  // Low log2(N) bits count modulo N for wrap bursts; linear uses the full word address.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] bte);
    logic [ADDR_WIDTH-1:0] m;
    case (bte)
      BTE_WRAP4:  m = ADDR_WIDTH'(3);
      BTE_WRAP8:  m = ADDR_WIDTH'(7);
      BTE_WRAP16: m = ADDR_WIDTH'(15);
      default:    m = '1;
    endcase
    return (a & ~m) | ((a + ADDR_WIDTH'(1)) & m);
  endfunction

  assign req_addr = S_ADR_I[ADDR_WIDTH+1:2];
  assign hit      = (S_ADR_I[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_addr = addr_q;
    rd_en   = 1'b0;
    if (!S_CYC_I) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (S_STB_I) begin
            if (!hit || !cti_supported(S_CTI_I)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              addr_d  = req_addr;
              rd_addr = req_addr;
              rd_en   = 1'b1;
              burst_d = (S_CTI_I == CTI_INCR);
              if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = 2'(WAIT_STATES - 1);
              end else begin
                state_d = (S_CTI_I == CTI_INCR) ? S_BURST : S_ACK;
                ack_d   = 1'b1;
              end
            end
          end
        end
        S_WAIT: begin
          rd_en = 1'b1;
          if (cnt_q == 2'd0) begin
            state_d = burst_q ? S_BURST : S_ACK;
            ack_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        S_ACK: state_d = S_IDLE;
        S_BURST: begin
          rd_en = 1'b1;
          // A taken beat prefetches the following word so the next cycle can ack again.
          if (S_STB_I && ack_q) begin
            if (S_CTI_I != CTI_INCR) begin
              state_d = S_IDLE;
            end else begin
              addr_d  = next_addr(addr_q, S_BTE_I);
              rd_addr = addr_d;
              ack_d   = 1'b1;
            end
          end else begin
            ack_d = S_STB_I;
          end
        end
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      burst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      burst_q <= burst_d;
    end
  end

  assign S_ACK_O = ack_q & S_CYC_I & S_STB_I;
  assign S_ERR_O = err_q & S_CYC_I & S_STB_I;
  assign S_RTY_O = 1'b0;
  assign wr_en   = S_ACK_O & S_WE_I & rst_n_i;

  lm32_wb_ram_core #(.ADDR_WIDTH(ADDR_WIDTH)) u_core (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (addr_q),
    .wr_sel  (S_SEL_I),
    .wr_data (S_DAT_I),
    .rd_data (S_DAT_O)
  );

endmodule

// File: tb/tb_lm32_wb_burst_ram.sv
// Directed bench for lm32_wb_burst_ram: classic, byte-lane, burst, stall, error, abort and reset cases.
module tb_lm32_wb_burst_ram;
  import lm32_wb_burst_ram_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          AW   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        we, lock, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] rlog [16];
  int          beats, stall_acks, bcycles;

  lm32_wb_burst_ram #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .S_ADR_I(adr), .S_DAT_I(wdat), .S_SEL_I(sel),
    .S_WE_I(we), .S_CTI_I(cti), .S_BTE_I(bte), .S_LOCK_I(lock), .S_CYC_I(cyc),
    .S_STB_I(stb), .S_DAT_O(rdat), .S_ACK_O(ack), .S_ERR_O(err), .S_RTY_O(rty)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(w * 4);
  endfunction

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [2:0] c, output logic [31:0] rd,
                         output logic got_ack, output logic got_err, output int lat);
    adr = a; wdat = d; sel = s; we = w; cti = c; cyc = 1'b1; stb = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; lat = 0; rd = '0;
    while (!got_ack && !got_err && lat < 16) begin
      @(negedge clk);
      lat++;
      got_ack = ack; got_err = err;
      if (ack) rd = rdat;
      @(posedge clk); #1;
    end
    bus_idle();
  endtask

  task automatic poke(input int word, input logic [31:0] d);
    logic [31:0] r; logic ga, ge; int l;
    classic(1'b1, wa(word), 4'hF, d, CTI_CLASSIC, r, ga, ge, l);
  endtask

  task automatic peek(input int word, output logic [31:0] d);
    logic ga, ge; int l;
    classic(1'b0, wa(word), 4'hF, 32'h0, CTI_CLASSIC, d, ga, ge, l);
  endtask

  task automatic burst(input logic w, input int word, input logic [1:0] b, input int n,
                       input logic [31:0] wbase, input int stall_at, input int stall_len);
    int stall_left; logic stalled;
    adr = wa(word); bte = b; we = w; sel = 4'hF; wdat = wbase;
    cti = (n == 1) ? CTI_END : CTI_INCR; cyc = 1'b1; stb = 1'b1;
    beats = 0; stall_acks = 0; bcycles = 0; stall_left = 0; stalled = 1'b0;
    while (beats < n && bcycles < 64) begin
      @(negedge clk);
      bcycles++;
      if (ack) begin
        if (!stb) stall_acks++;
        else begin rlog[beats] = rdat; beats++; end
      end
      @(posedge clk); #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stb = 1'b1;
      end else if (!stalled && stall_len > 0 && beats == stall_at) begin
        stb = 1'b0; stall_left = stall_len; stalled = 1'b1;
      end
      cti  = (beats >= n - 1) ? CTI_END : CTI_INCR;
      wdat = wbase + 32'(beats);
    end
    bus_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; bus_idle();
    adr = wa(0); cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %b want 0", ack); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    compared++; if (rty !== 1'b0) begin mismatched++; $display("FAIL reset_rty: got %b want 0", rty); end
    compared++; if (rdat !== 32'h0) begin mismatched++; $display("FAIL reset_dat: got %h want 0", rdat); end
    compared++; if (dut.state_q !== S_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
    bus_idle(); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_classic_read();
    poke(4, 32'hDEAD_BEEF);
    adr = wa(4); we = 1'b0; sel = 4'hF; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL classic_c1_ack: got %b want 0", ack); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (ack !== 1'b1) begin mismatched++; $display("FAIL classic_c2_ack: got %b want 1", ack); end
    compared++; if (rdat !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL classic_dat: got %h want deadbeef", rdat); end
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL classic_c3_ack: got %b want 0", ack); end
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    logic [31:0] r; logic ga, ge; int l;
    poke(8, 32'hAAAA_AAAA);
    classic(1'b1, wa(8), 4'b0011, 32'h1122_3344, CTI_CLASSIC, r, ga, ge, l);
    compared++; if (ga !== 1'b1) begin mismatched++; $display("FAIL bytewr_ack: got %b want 1", ga); end
    peek(8, r);
    compared++; if (r !== 32'hAAAA_3344) begin mismatched++; $display("FAIL bytewr_lo: got %h want aaaa3344", r); end
    classic(1'b1, wa(8), 4'b1000, 32'h5566_7788, CTI_END, r, ga, ge, l);
    peek(8, r);
    compared++; if (r !== 32'h55AA_3344) begin mismatched++; $display("FAIL bytewr_hi: got %h want 55aa3344", r); end
  endtask

  task automatic test_wrap4();
    logic [31:0] exp [4];
    for (int i = 4; i < 8; i++) poke(i, 32'hC0DE_0000 + 32'(i));
    exp[0] = 32'hC0DE_0006; exp[1] = 32'hC0DE_0007; exp[2] = 32'hC0DE_0004; exp[3] = 32'hC0DE_0005;
    burst(1'b0, 6, BTE_WRAP4, 4, 32'h0, 0, 0);
    compared++; if (beats !== 4) begin mismatched++; $display("FAIL wrap4_beats: got %0d want 4", beats); end
    compared++; if (bcycles !== 5) begin mismatched++; $display("FAIL wrap4_cycles: got %0d want 5", bcycles); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rlog[i] !== exp[i]) begin mismatched++; $display("FAIL wrap4_beat%0d: got %h want %h", i, rlog[i], exp[i]); end
    end
    @(negedge clk);
    compared++; if (dut.state_q !== S_IDLE) begin mismatched++; $display("FAIL wrap4_idle: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
  endtask

  task automatic test_linear_stall();
    logic [31:0] r;
    burst(1'b1, 8'h40, BTE_LINEAR, 8, 32'h5000_0000, 0, 0);
    compared++; if (beats !== 8) begin mismatched++; $display("FAIL linwr_beats: got %0d want 8", beats); end
    peek(8'h47, r);
    compared++; if (r !== 32'h5000_0007) begin mismatched++; $display("FAIL linwr_last: got %h want 50000007", r); end
    burst(1'b0, 8'h40, BTE_LINEAR, 8, 32'h0, 3, 2);
    compared++; if (beats !== 8) begin mismatched++; $display("FAIL stall_beats: got %0d want 8", beats); end
    compared++; if (stall_acks !== 0) begin mismatched++; $display("FAIL stall_acks: got %0d want 0", stall_acks); end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (rlog[i] !== 32'h5000_0000 + 32'(i)) begin
        mismatched++; $display("FAIL stall_beat%0d: got %h want %h", i, rlog[i], 32'h5000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_top_wrap();
    poke(255, 32'h7070_FFFF);
    poke(0,   32'h7070_0000);
    burst(1'b0, 255, BTE_LINEAR, 2, 32'h0, 0, 0);
    compared++; if (rlog[0] !== 32'h7070_FFFF) begin mismatched++; $display("FAIL topwrap_b0: got %h want 7070ffff", rlog[0]); end
    compared++; if (rlog[1] !== 32'h7070_0000) begin mismatched++; $display("FAIL topwrap_b1: got %h want 70700000", rlog[1]); end
  endtask

  task automatic test_error();
    logic [31:0] r; logic ga, ge; int l;
    classic(1'b1, wa(256), 4'hF, 32'hFFFF_FFFF, CTI_CLASSIC, r, ga, ge, l);
    compared++; if (ge !== 1'b1) begin mismatched++; $display("FAIL range_err: got %b want 1", ge); end
    compared++; if (ga !== 1'b0) begin mismatched++; $display("FAIL range_ack: got %b want 0", ga); end
    compared++; if (l !== 2) begin mismatched++; $display("FAIL range_lat: got %0d want 2", l); end
    classic(1'b1, BASE - 32'd4, 4'hF, 32'hFFFF_FFFF, CTI_CLASSIC, r, ga, ge, l);
    compared++; if (ge !== 1'b1) begin mismatched++; $display("FAIL below_err: got %b want 1", ge); end
    classic(1'b1, wa(0), 4'hF, 32'hFFFF_FFFF, 3'b001, r, ga, ge, l);
    compared++; if (ge !== 1'b1) begin mismatched++; $display("FAIL cti_err: got %b want 1", ge); end
    compared++; if (ga !== 1'b0) begin mismatched++; $display("FAIL cti_ack: got %b want 0", ga); end
    peek(0, r);
    compared++; if (r !== 32'h7070_0000) begin mismatched++; $display("FAIL err_ram: got %h want 70700000", r); end
    peek(255, r);
    compared++; if (r !== 32'h7070_FFFF) begin mismatched++; $display("FAIL err_ram_top: got %h want 7070ffff", r); end
  endtask

  task automatic test_cyc_drop();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) poke(8'h80 + i, 32'h1111_0000 + 32'(i));
    adr = wa(8'h80); we = 1'b1; sel = 4'hF; cti = CTI_INCR; bte = BTE_LINEAR;
    wdat = 32'hAB00_0000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    compared++; if (ack !== 1'b1) begin mismatched++; $display("FAIL drop_beat1_ack: got %b want 1", ack); end
    @(posedge clk); #1;
    wdat = 32'hAB00_0001; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    compared++; if (dut.state_q !== S_IDLE) begin mismatched++; $display("FAIL drop_idle: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
    bus_idle();
    peek(8'h80, r);
    compared++; if (r !== 32'hAB00_0000) begin mismatched++; $display("FAIL drop_w0: got %h want ab000000", r); end
    peek(8'h81, r);
    compared++; if (r !== 32'h1111_0001) begin mismatched++; $display("FAIL drop_w1: got %h want 11110001", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    poke(8'h90, 32'h2222_0000);
    poke(8'h91, 32'h2222_0001);
    adr = wa(8'h90); we = 1'b1; sel = 4'hF; cti = CTI_INCR; bte = BTE_LINEAR;
    wdat = 32'hCD00_0000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    compared++; if (ack !== 1'b1) begin mismatched++; $display("FAIL rstmid_beat1_ack: got %b want 1", ack); end
    @(posedge clk); #1;
    wdat = 32'hCD00_0001; rst_n = 1'b0;
    @(negedge clk);
    compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL rstmid_ack: got %b want 0", ack); end
    compared++; if (rdat !== 32'h0) begin mismatched++; $display("FAIL rstmid_dat: got %h want 0", rdat); end
    compared++; if (dut.state_q !== S_IDLE) begin mismatched++; $display("FAIL rstmid_idle: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
    bus_idle(); rst_n = 1'b1;
    @(posedge clk); #1;
    peek(8'h90, r);
    compared++; if (r !== 32'hCD00_0000) begin mismatched++; $display("FAIL rstmid_w0: got %h want cd000000", r); end
    peek(8'h91, r);
    compared++; if (r !== 32'h2222_0001) begin mismatched++; $display("FAIL rstmid_w1: got %h want 22220001", r); end
  endtask

  initial begin
    adr = '0; wdat = '0;
    test_reset();
    test_classic_read();
    test_byte_write();
    test_wrap4();
    test_linear_stall();
    test_top_wrap();
    test_error();
    test_cyc_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
